// File: rtl/inst_fetch_queue.sv
// rtl/inst_fetch_queue.sv - sequential instruction prefetch queue with redirect and stale-fetch drop
module inst_fetch_queue #(
    parameter int          DEPTH    = 4,
    parameter logic [31:0] RESET_PC = 32'h0
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     redirect_valid,
    input  logic [31:0]              redirect_pc,
    output logic                     mem_req,
    output logic [31:0]              mem_addr,
    input  logic                     mem_ack,
    input  logic [31:0]              mem_rdata,
    output logic                     out_valid,
    output logic [31:0]              out_pc,
    output logic [31:0]              out_inst,
    input  logic                     out_ready,
    output logic [$clog2(DEPTH):0]   count
);

    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;
    localparam logic [CW-1:0] DEPTH_C = CW'(DEPTH);

    typedef enum logic [1:0] {IDLE, REQ, DROP} state_t;

    state_t        state_q, state_d;
    logic [31:0]   fetch_pc_q, fetch_pc_d;
    logic [31:0]   req_addr_q, req_addr_d;
    logic [AW-1:0] wr_ptr_q, rd_ptr_q;
    logic [CW-1:0] count_q;
    logic [31:0]   pc_mem_q   [DEPTH];
    logic [31:0]   inst_mem_q [DEPTH];

    logic          acked;
    logic          push;
    logic          pop;
    logic [CW-1:0] count_after;

    assign acked       = mem_ack && (state_q != IDLE);
    assign push        = !redirect_valid && (state_q == REQ) && mem_ack;
    assign pop         = !redirect_valid && out_valid && out_ready;
    assign count_after = count_q + CW'(push) - CW'(pop);

    assign mem_req   = (state_q != IDLE);
    assign mem_addr  = req_addr_q;
    assign out_valid = (count_q != '0);
    assign out_pc    = pc_mem_q[rd_ptr_q];
    assign out_inst  = inst_mem_q[rd_ptr_q];
    assign count     = count_q;

    always_comb begin
        state_d    = state_q;
        fetch_pc_d = fetch_pc_q;
        req_addr_d = req_addr_q;
        if (redirect_valid) begin
            // An outstanding unacked fetch must complete before the new target can go on the bus.
            if (state_q == IDLE || acked) begin
                state_d    = REQ;
                req_addr_d = redirect_pc;
                fetch_pc_d = redirect_pc + 32'd4;
            end else begin
                state_d    = DROP;
                fetch_pc_d = redirect_pc;
            end
        end else begin
            case (state_q)
                IDLE: begin
                    if (count_q < DEPTH_C) begin
                        state_d    = REQ;
                        req_addr_d = fetch_pc_q;
                        fetch_pc_d = fetch_pc_q + 32'd4;
                    end
                end
                REQ: begin
                    if (acked) begin
                        if (count_after < DEPTH_C) begin
                            req_addr_d = fetch_pc_q;
                            fetch_pc_d = fetch_pc_q + 32'd4;
                        end else begin
                            state_d = IDLE;
                        end
                    end
                end
                DROP: begin
                    if (acked) begin
                        state_d    = REQ;
                        req_addr_d = fetch_pc_q;
                        fetch_pc_d = fetch_pc_q + 32'd4;
                    end
                end
                default: state_d = IDLE;
            endcase
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q    <= IDLE;
            fetch_pc_q <= RESET_PC;
            req_addr_q <= RESET_PC;
            wr_ptr_q   <= '0;
            rd_ptr_q   <= '0;
            count_q    <= '0;
            for (int i = 0; i < DEPTH; i++) begin
                pc_mem_q[i]   <= '0;
                inst_mem_q[i] <= '0;
            end
        end else begin
            state_q    <= state_d;
            fetch_pc_q <= fetch_pc_d;
            req_addr_q <= req_addr_d;
            if (redirect_valid) begin
                wr_ptr_q <= '0;
                rd_ptr_q <= '0;
                count_q  <= '0;
            end else begin
                if (push) begin
                    pc_mem_q[wr_ptr_q]   <= req_addr_q;
                    inst_mem_q[wr_ptr_q] <= mem_rdata;
                    wr_ptr_q             <= wr_ptr_q + AW'(1);
                end
                if (pop) begin
                    rd_ptr_q <= rd_ptr_q + AW'(1);
                end
                count_q <= count_after;
            end
        end
    end

endmodule
